y86_bus_arbiter: RTL and testbench

//  Shares the single y86 memory bus between the y86_seq core (master 0) and a

---
 rtl/y86_bus_arbiter_if.sv | 49 ++++
 rtl/y86_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_y86_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_bus_arbiter_if.sv
// Bus bundle between the y86 core, the DMA/debug master, the memory and the
// arbiter. The arbiter uses the slave view; the surrounding system uses master.
interface y86_bus_arbiter_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    core_addr;
  logic             core_re;
  logic             core_we;
  logic [DW-1:0]    core_wdata;
  logic [DW-1:0]    core_rdata;

  logic             dma_req;
  logic             dma_we;
  logic [AW-1:0]    dma_addr;
  logic [DW-1:0]    dma_wdata;
  logic             dma_gnt;
  logic             dma_ack;
  logic [DW-1:0]    dma_rdata;

  logic [AW-1:0]    mem_addr;
  logic             mem_re;
  logic             mem_we;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  logic             starve;
  logic             core_err;
  logic [CNT_W-1:0] dma_count;

  modport slave (
    input  core_addr, core_re, core_we, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_rdata, dma_gnt, dma_ack, dma_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata,
    output starve, core_err, dma_count
  );

  modport master (
    output core_addr, core_re, core_we, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_rdata, dma_gnt, dma_ack, dma_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    input  starve, core_err, dma_count
  );
endinterface

// File: rtl/y86_bus_arbiter.sv
// Memory bus arbiter: the y86 core always wins and passes straight through;
// a single DMA/debug request is latched and issued in the first idle core
// cycle, then acknowledged with a one-cycle pulse.
module y86_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  y86_bus_arbiter_if.slave bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t           state_q, state_d;
  logic             weL_q, weL_d;
  logic [AW-1:0]    addrL_q, addrL_d;
  logic [DW-1:0]    wdataL_q, wdataL_d;
  logic [WCW-1:0]   waitCnt_q, waitCnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             starve_q, starve_d;
  logic             coreErr_q, coreErr_d;
  logic             coreBusy;

  assign coreBusy        = bus.core_re | bus.core_we;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dma_rdata   = rdata_q;
  assign bus.dma_count   = count_q;
  assign bus.starve      = starve_q;
  assign bus.core_err    = coreErr_q;

  // State and datapath registers; reset drops any in-flight DMA transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      weL_q     <= 1'b0;
      addrL_q   <= '0;
      wdataL_q  <= '0;
      waitCnt_q <= '0;
      rdata_q   <= '0;
      count_q   <= '0;
      starve_q  <= 1'b0;
      coreErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      weL_q     <= weL_d;
      addrL_q   <= addrL_d;
      wdataL_q  <= wdataL_d;
      waitCnt_q <= waitCnt_d;
      rdata_q   <= rdata_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      coreErr_q <= coreErr_d;
    end
  end

  // Next-state and bus muxing: core pass-through first, DMA only when core idle.
  always_comb begin
    state_d       = state_q;
    weL_d         = weL_q;
    addrL_d       = addrL_q;
    wdataL_d      = wdataL_q;
    waitCnt_d     = waitCnt_q;
    rdata_d       = rdata_q;
    count_d       = count_q;
    starve_d      = starve_q;
    coreErr_d     = coreErr_q | (bus.core_re & bus.core_we);
    bus.dma_gnt   = 1'b0;
    bus.dma_ack   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;

    if (coreBusy) begin
      bus.mem_addr  = bus.core_addr;
      bus.mem_re    = bus.core_re;
      bus.mem_we    = bus.core_we;
      bus.mem_wdata = bus.core_wdata;
    end

    case (state_q)
      IDLE: begin
        bus.dma_gnt = bus.dma_req & rst_n;
        if (bus.dma_req) begin
          weL_d    = bus.dma_we;
          addrL_d  = bus.dma_addr;
          wdataL_d = bus.dma_wdata;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (coreBusy) begin
          if (waitCnt_q != WCW'(MAX_WAIT)) begin
            waitCnt_d = waitCnt_q + WCW'(1);
          end
          if (waitCnt_d >= WCW'(MAX_WAIT)) begin
            starve_d = 1'b1;
          end
        end else begin
          bus.mem_addr  = addrL_q;
          bus.mem_wdata = wdataL_q;
          bus.mem_re    = ~weL_q;
          bus.mem_we    = weL_q;
          if (!weL_q) begin
            rdata_d = bus.mem_rdata;
          end
          waitCnt_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        bus.dma_ack = 1'b1;
        count_d     = count_q + CNT_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Self-checking bench for y86_bus_arbiter: directed timing checks plus a
// scoreboard of expected DMA issues/acks, against a small word memory model.
module tb_y86_bus_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } sb_t;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  sb_t              sbQ[$];
  sb_t              monEntry;
  logic [CNT_W-1:0] expCount;
  logic [DW-1:0]    expLastRdata;
  logic [DW-1:0]    memArr [0:255];

  y86_bus_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) bus ();

  y86_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read and clocked memory write
  assign bus.mem_rdata = memArr[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (bus.mem_we) memArr[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.dma_req = 1'b0;
    bus.core_re = 1'b0;
    bus.core_we = 1'b0;
    sbQ.delete();
    expCount = '0;
    expLastRdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Drives a DMA request in an IDLE cycle, checks the grant, records expectation
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    sb_t e;
    bus.dma_req   = 1'b1;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
    #1;
    checkOutput("gnt", bus.dma_gnt, 1'b1);
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? expLastRdata : memArr[addr[7:0]];
    expLastRdata = e.rdata;
    sbQ.push_back(e);
  endtask

  task automatic waitAck(input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (bus.dma_ack) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(tag, found, 1'b1);
  endtask

  // Scoreboard monitor: DMA issue cycles and acks are compared to the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if ((bus.mem_re || bus.mem_we) && !(bus.core_re || bus.core_we)) begin
        if (sbQ.size() == 0) begin
          checkOutput("issue_unexpected", 1'b1, 1'b0);
        end else begin
          checkOutput("issue_addr", bus.mem_addr, sbQ[0].addr);
          checkOutput("issue_we", bus.mem_we, sbQ[0].we);
          if (sbQ[0].we) checkOutput("issue_wdata", bus.mem_wdata, sbQ[0].wdata);
        end
      end
      if (bus.dma_ack) begin
        if (sbQ.size() == 0) begin
          checkOutput("ack_unexpected", 1'b1, 1'b0);
        end else begin
          monEntry = sbQ.pop_front();
          checkOutput("ack_rdata", bus.dma_rdata, monEntry.rdata);
          checkOutput("ack_count", bus.dma_count, expCount);
          expCount = expCount + 1'b1;
        end
      end
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    expCount = '0;
    expLastRdata = '0;
    for (int i = 0; i < 256; i++) memArr[i] = 32'h1000_0000 + i;
    memArr[8'h40] = 32'h1234_5678;
    rst_n = 1'b0;
    bus.core_addr = '0;
    bus.core_re = 1'b0;
    bus.core_we = 1'b0;
    bus.core_wdata = '0;
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b0;
    bus.dma_addr = '0;
    bus.dma_wdata = '0;

    // Reset state, with dma_req high that must not grant
    #2;
    checkOutput("rst_gnt", bus.dma_gnt, 1'b0);
    checkOutput("rst_ack", bus.dma_ack, 1'b0);
    checkOutput("rst_count", bus.dma_count, 0);
    checkOutput("rst_rdata", bus.dma_rdata, 0);
    checkOutput("rst_starve", bus.starve, 0);
    checkOutput("rst_core_err", bus.core_err, 0);
    checkOutput("rst_mem_re", bus.mem_re, 0);
    doReset();

    // Core pass-through read and write
    bus.core_re = 1'b1;
    bus.core_addr = 32'h10;
    #1;
    checkOutput("core_rd_re", bus.mem_re, 1'b1);
    checkOutput("core_rd_addr", bus.mem_addr, 32'h10);
    checkOutput("core_rdata", bus.core_rdata, 32'h1000_0010);
    bus.core_re = 1'b0;
    bus.core_we = 1'b1;
    bus.core_addr = 32'h14;
    bus.core_wdata = 32'hCAFE_0014;
    #1;
    checkOutput("core_wr_we", bus.mem_we, 1'b1);
    checkOutput("core_wr_re", bus.mem_re, 1'b0);
    checkOutput("core_wr_wdata", bus.mem_wdata, 32'hCAFE_0014);
    tick();
    bus.core_we = 1'b0;
    #1;
    checkOutput("idle_addr", bus.mem_addr, 0);

    // Test 1: DMA read, best-case latency
    applyStimulus(1'b0, 32'h40, 32'h0);
    checkOutput("t1_n_mem_re", bus.mem_re, 1'b0);
    tick();
    bus.dma_req = 1'b0;
    #1;
    checkOutput("t1_n1_mem_re", bus.mem_re, 1'b1);
    checkOutput("t1_n1_addr", bus.mem_addr, 32'h40);
    checkOutput("t1_n1_ack", bus.dma_ack, 1'b0);
    tick();
    #1;
    checkOutput("t1_n2_ack", bus.dma_ack, 1'b1);
    checkOutput("t1_n2_rdata", bus.dma_rdata, 32'h1234_5678);
    checkOutput("t1_n2_mem_re", bus.mem_re, 1'b0);
    tick();
    #1;
    checkOutput("t1_ack_pulse", bus.dma_ack, 1'b0);
    checkOutput("t1_count", bus.dma_count, 1);

    // Test 2: DMA write held off by two core read cycles
    applyStimulus(1'b1, 32'h80, 32'hDEAD_BEEF);
    tick();
    bus.dma_req = 1'b0;
    bus.core_re = 1'b1;
    bus.core_addr = 32'h20;
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("t2_core_addr", bus.mem_addr, 32'h20);
      checkOutput("t2_core_we", bus.mem_we, 1'b0);
      tick();
    end
    bus.core_re = 1'b0;
    #1;
    checkOutput("t2_dma_we", bus.mem_we, 1'b1);
    checkOutput("t2_dma_addr", bus.mem_addr, 32'h80);
    checkOutput("t2_dma_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    #1;
    checkOutput("t2_ack", bus.dma_ack, 1'b1);
    checkOutput("t2_rdata_held", bus.dma_rdata, 32'h1234_5678);
    tick();
    bus.core_re = 1'b1;
    bus.core_addr = 32'h80;
    #1;
    checkOutput("t2_mem_written", bus.core_rdata, 32'hDEAD_BEEF);
    tick();
    bus.core_re = 1'b0;

    // Test 3a: seven busy cycles must not set starve
    applyStimulus(1'b0, 32'h44, 32'h0);
    tick();
    bus.dma_req = 1'b0;
    bus.core_re = 1'b1;
    bus.core_addr = 32'h30;
    repeat (6) tick();
    tick();
    bus.core_re = 1'b0;
    #1;
    checkOutput("t3a_starve", bus.starve, 1'b0);
    checkOutput("t3a_issue", bus.mem_re, 1'b1);
    tick();
    checkOutput("t3a_ack", bus.dma_ack, 1'b1);
    tick();

    // Test 3b: eight busy cycles set sticky starve; transfer still completes
    applyStimulus(1'b0, 32'h48, 32'h0);
    tick();
    bus.dma_req = 1'b0;
    bus.core_re = 1'b1;
    bus.core_addr = 32'h34;
    repeat (7) tick();
    tick();
    bus.core_re = 1'b0;
    #1;
    checkOutput("t3b_starve", bus.starve, 1'b1);
    waitAck(4, "t3b_ack");
    repeat (3) tick();
    checkOutput("t3b_starve_sticky", bus.starve, 1'b1);

    // Test 4: simultaneous core read and write
    bus.core_re = 1'b1;
    bus.core_we = 1'b1;
    bus.core_addr = 32'h60;
    bus.core_wdata = 32'h5;
    #1;
    checkOutput("t4_mem_re", bus.mem_re, 1'b1);
    checkOutput("t4_mem_we", bus.mem_we, 1'b1);
    checkOutput("t4_err_before", bus.core_err, 1'b0);
    tick();
    bus.core_re = 1'b0;
    bus.core_we = 1'b0;
    #1;
    checkOutput("t4_core_err", bus.core_err, 1'b1);
    repeat (3) tick();
    checkOutput("t4_core_err_sticky", bus.core_err, 1'b1);

    // Test 5: reset while a request is pending
    applyStimulus(1'b0, 32'h50, 32'h0);
    tick();
    bus.dma_req = 1'b0;
    bus.core_re = 1'b1;
    bus.core_addr = 32'h38;
    #1;
    rst_n = 1'b0;
    sbQ.delete();
    expCount = '0;
    expLastRdata = '0;
    #1;
    checkOutput("t5_count", bus.dma_count, 0);
    checkOutput("t5_starve", bus.starve, 1'b0);
    checkOutput("t5_core_err", bus.core_err, 1'b0);
    checkOutput("t5_rdata", bus.dma_rdata, 0);
    checkOutput("t5_passthru", bus.mem_re, 1'b1);
    tick();
    rst_n = 1'b1;
    bus.core_re = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("t5_no_ack", bus.dma_ack, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h50, 32'h0);
    tick();
    bus.dma_req = 1'b0;
    waitAck(4, "t5_ack_after_reset");
    tick();

    // Test 6: held request, 2^CNT_W+1 back-to-back reads, counter wraps to 1
    doReset();
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b0;
    bus.dma_addr = 32'h4C;
    for (int i = 0; i < 3 * ((1 << CNT_W) + 1); i++) begin
      #1;
      checkOutput("t6_gnt", bus.dma_gnt, (i % 3) == 0);
      if ((i % 3) == 0) begin
        monEntry.we = 1'b0;
        monEntry.addr = 32'h4C;
        monEntry.wdata = '0;
        monEntry.rdata = memArr[8'h4C];
        sbQ.push_back(monEntry);
      end
      tick();
    end
    bus.dma_req = 1'b0;
    tick();
    checkOutput("t6_queue_empty", sbQ.size(), 0);
    checkOutput("t6_count_wrap", bus.dma_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
